// File: rtl/dds_pkg.sv
// dds_pkg: state encodings and switch timing defaults shared by the DDS source switch and the sequencers.
`default_nettype none

package dds_pkg;

  localparam logic [1:0] ST_RUN   = 2'd0;
  localparam logic [1:0] ST_DRAIN = 2'd1;
  localparam logic [1:0] ST_GUARD = 2'd2;

  localparam int DDS_GUARD_CYC = 4;
  localparam int DDS_DRAIN_MAX = 1000;

  typedef enum logic [1:0] {
    S_RUN   = ST_RUN,
    S_DRAIN = ST_DRAIN,
    S_GUARD = ST_GUARD
  } state_t;

endpackage

`default_nettype wire

// File: rtl/dds_src_switch_if.sv
// dds_src_switch_if: sequencer-bank side select/strobe bundle and DDS-side outputs of the source switch.
`default_nettype none

interface dds_src_switch_if #(
  parameter int NUM_SRC = 4,
  parameter int SEL_W   = 2
);

  logic [SEL_W-1:0]   sel_req;
  logic               sel_valid;
  logic [NUM_SRC-1:0] rst_in;
  logic [NUM_SRC-1:0] conf_in;
  logic               dds_rst;
  logic               dds_conf;
  logic [SEL_W-1:0]   sel_cur;
  logic               busy;
  logic               sel_err;
  logic               drain_to;

  modport master (
    output sel_req, sel_valid, rst_in, conf_in,
    input  dds_rst, dds_conf, sel_cur, busy, sel_err, drain_to
  );

  modport slave (
    input  sel_req, sel_valid, rst_in, conf_in,
    output dds_rst, dds_conf, sel_cur, busy, sel_err, drain_to
  );

endinterface

`default_nettype wire

// File: rtl/dds_src_mux.sv
// dds_src_mux: combinational selection of one source's reset/config strobe by index.
`default_nettype none

module dds_src_mux #(
  parameter int NUM_SRC = 4,
  parameter int SEL_W   = 2
) (
  input  logic [SEL_W-1:0]   sel,
  input  logic [NUM_SRC-1:0] rst_in,
  input  logic [NUM_SRC-1:0] conf_in,
  output logic               rst_sel,
  output logic               conf_sel
);

  // Indices at or above NUM_SRC have no source behind them and read as 0.
  always_comb begin
    rst_sel  = 1'b0;
    conf_sel = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (sel == SEL_W'(i)) begin
        rst_sel  = rst_in[i];
        conf_sel = conf_in[i];
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/dds_src_switch.sv
// dds_src_switch: glitch-safe N-source switch for the DDS reset/config pins (drain, guard gap, hand over).
`default_nettype none

module dds_src_switch
  import dds_pkg::*;
#(
  parameter int NUM_SRC   = 4,
  parameter int SEL_W     = 2,
  parameter int GUARD_CYC = DDS_GUARD_CYC,
  parameter int DRAIN_MAX = DDS_DRAIN_MAX
) (
  input  logic             clk_sys,
  input  logic             rst_n,
  dds_src_switch_if.slave  bus
);

  localparam logic [7:0]  GUARD_LAST = 8'(GUARD_CYC - 1);
  localparam logic [15:0] DRAIN_LAST = 16'(DRAIN_MAX - 1);

  state_t           state;
  logic [SEL_W-1:0] sel_cur;
  logic [SEL_W-1:0] pending;
  logic [7:0]       guard_cnt;
  logic [15:0]      drain_cnt;
  logic             dds_rst;
  logic             dds_conf;
  logic             busy;
  logic             sel_err;
  logic             drain_to;
  logic             mux_rst;
  logic             mux_conf;
  logic             req_ok;

  dds_src_mux #(
    .NUM_SRC (NUM_SRC),
    .SEL_W   (SEL_W)
  ) u_mux (
    .sel      (sel_cur),
    .rst_in   (bus.rst_in),
    .conf_in  (bus.conf_in),
    .rst_sel  (mux_rst),
    .conf_sel (mux_conf)
  );

  assign req_ok = (int'(bus.sel_req) < NUM_SRC);

  always_ff @(posedge clk_sys) begin
    if (!rst_n) begin
      state     <= S_RUN;
      sel_cur   <= '0;
      pending   <= '0;
      guard_cnt <= '0;
      drain_cnt <= '0;
      dds_rst   <= 1'b0;
      dds_conf  <= 1'b0;
      busy      <= 1'b0;
      sel_err   <= 1'b0;
      drain_to  <= 1'b0;
    end else begin
      sel_err  <= 1'b0;
      drain_to <= 1'b0;
      case (state)
        S_RUN: begin
          dds_rst  <= mux_rst;
          dds_conf <= mux_conf;
          if (bus.sel_valid) begin
            if (!req_ok) begin
              sel_err <= 1'b1;
            end else if (bus.sel_req != sel_cur) begin
              pending <= bus.sel_req;
              busy    <= 1'b1;
              // An idle source has no burst to drain; go straight to the gap.
              if (mux_conf) begin
                state     <= S_DRAIN;
                drain_cnt <= '0;
              end else begin
                state     <= S_GUARD;
                guard_cnt <= '0;
              end
            end
          end
        end
        S_DRAIN: begin
          dds_rst  <= mux_rst;
          dds_conf <= mux_conf;
          if (bus.sel_valid) sel_err <= 1'b1;
          if (!mux_conf) begin
            state     <= S_GUARD;
            guard_cnt <= '0;
          end else if (drain_cnt >= DRAIN_LAST) begin
            state     <= S_GUARD;
            guard_cnt <= '0;
            drain_to  <= 1'b1;
          end else if (drain_cnt != '1) begin
            drain_cnt <= drain_cnt + 16'd1;
          end
        end
        S_GUARD: begin
          dds_rst  <= 1'b0;
          dds_conf <= 1'b0;
          if (bus.sel_valid) sel_err <= 1'b1;
          if (guard_cnt >= GUARD_LAST) begin
            sel_cur <= pending;
            busy    <= 1'b0;
            state   <= S_RUN;
          end else if (guard_cnt != '1) begin
            guard_cnt <= guard_cnt + 8'd1;
          end
        end
        default: begin
          state <= S_RUN;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.dds_rst  = dds_rst;
  assign bus.dds_conf = dds_conf;
  assign bus.sel_cur  = sel_cur;
  assign bus.busy     = busy;
  assign bus.sel_err  = sel_err;
  assign bus.drain_to = drain_to;

endmodule

`default_nettype wire

// File: tb/tb_dds_src_switch.sv
// tb_dds_src_switch: directed vectors with a cycle-tagged expectation queue checked by a separate monitor.
`default_nettype none

module tb_dds_src_switch;

  logic clk_sys;
  logic rst_n;
  int   cyc_cnt;
  int   tests;
  int   fails;

  typedef struct {
    int         cyc;
    logic [7:0] v;
    string      name;
  } exp_t;

  exp_t       sb[$];
  exp_t       mon_x;
  logic [7:0] mon_got;

  dds_src_switch_if #(.NUM_SRC(4), .SEL_W(3)) bus ();

  dds_src_switch #(
    .NUM_SRC   (4),
    .SEL_W     (3),
    .GUARD_CYC (4),
    .DRAIN_MAX (8)
  ) dut (
    .clk_sys (clk_sys),
    .rst_n   (rst_n),
    .bus     (bus)
  );

  initial clk_sys = 1'b0;
  always #5 clk_sys = ~clk_sys;

  initial cyc_cnt = 0;
  always @(posedge clk_sys) cyc_cnt <= cyc_cnt + 1;

  // Expected vector layout: {dds_rst, dds_conf, sel_cur[2:0], busy, sel_err, drain_to}
  function automatic logic [7:0] ex(input int r, input int c, input int s,
                                    input int b, input int e, input int t);
    return {r[0], c[0], s[2:0], b[0], e[0], t[0]};
  endfunction

  always @(negedge clk_sys) begin
    if (sb.size() > 0 && sb[0].cyc == cyc_cnt) begin
      mon_x   = sb.pop_front();
      mon_got = {bus.dds_rst, bus.dds_conf, bus.sel_cur, bus.busy, bus.sel_err, bus.drain_to};
      tests++;
      if (mon_got !== mon_x.v) begin
        fails++;
        $display("FAIL %s (cyc %0d): got rst=%b conf=%b sel=%0d busy=%b err=%b to=%b, expected rst=%b conf=%b sel=%0d busy=%b err=%b to=%b",
                 mon_x.name, cyc_cnt,
                 mon_got[7], mon_got[6], mon_got[5:3], mon_got[2], mon_got[1], mon_got[0],
                 mon_x.v[7], mon_x.v[6], mon_x.v[5:3], mon_x.v[2], mon_x.v[1], mon_x.v[0]);
      end
    end
  end

  // Drive one cycle of inputs; ev is the DUT state right after the next edge.
  task automatic step(input logic rn, input logic v, input logic [2:0] req,
                      input logic [3:0] ri, input logic [3:0] ci,
                      input logic [7:0] ev, input string nm);
    exp_t x;
    rst_n         = rn;
    bus.sel_valid = v;
    bus.sel_req   = req;
    bus.rst_in    = ri;
    bus.conf_in   = ci;
    x.cyc  = cyc_cnt + 1;
    x.v    = ev;
    x.name = nm;
    sb.push_back(x);
    @(posedge clk_sys);
    #1;
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst_n         = 1'b0;
    bus.sel_valid = 1'b0;
    bus.sel_req   = '0;
    bus.rst_in    = '0;
    bus.conf_in   = '0;
    @(posedge clk_sys);
    #1;

    // Reset, then idle on source 0
    for (int i = 0; i < 3; i++) step(0, 0, 0, 4'b1111, 4'b1111, ex(0,0,0,0,0,0), "reset");
    step(1, 0, 0, 4'b0010, 4'b0000, ex(0,0,0,0,0,0), "idle_src0");
    step(1, 0, 0, 4'b0010, 4'b0000, ex(0,0,0,0,0,0), "idle_src0");
    step(1, 0, 0, 4'b0001, 4'b0001, ex(1,1,0,0,0,0), "pass_src0");

    // Clean switch 0 -> 2 (source 0 idle)
    step(1, 1, 2, 4'b0100, 4'b0100, ex(0,0,0,1,0,0), "clean_accept");
    for (int i = 0; i < 3; i++) step(1, 0, 0, 4'b0100, 4'b0100, ex(0,0,0,1,0,0), "clean_guard");
    step(1, 0, 0, 4'b0100, 4'b0100, ex(0,0,2,0,0,0), "clean_handover");
    step(1, 0, 0, 4'b0100, 4'b0100, ex(1,1,2,0,0,0), "clean_pass_src2");
    step(1, 1, 2, 4'b0000, 4'b0100, ex(0,1,2,0,0,0), "same_sel_noop");

    // Out-of-range requests
    step(1, 1, 5, 4'b0000, 4'b0000, ex(0,0,2,0,1,0), "reject_5");
    step(1, 0, 0, 4'b0000, 4'b0000, ex(0,0,2,0,0,0), "err_one_cycle");
    step(1, 1, 4, 4'b0000, 4'b0000, ex(0,0,2,0,1,0), "reject_4");

    // Drain 2 -> 1; conf drops exactly on the last allowed drain cycle
    step(1, 1, 1, 4'b0000, 4'b0110, ex(0,1,2,1,0,0), "drain_accept");
    for (int i = 0; i < 2; i++) step(1, 0, 0, 4'b0000, 4'b0110, ex(0,1,2,1,0,0), "drain_hold");
    step(1, 1, 3, 4'b0000, 4'b0110, ex(0,1,2,1,1,0), "drain_busy_reject");
    for (int i = 0; i < 4; i++) step(1, 0, 0, 4'b0000, 4'b0110, ex(0,1,2,1,0,0), "drain_hold");
    step(1, 0, 0, 4'b0000, 4'b0010, ex(0,0,2,1,0,0), "drain_exit_tie");
    for (int i = 0; i < 3; i++) step(1, 0, 0, 4'b0000, 4'b0010, ex(0,0,2,1,0,0), "drain_guard");
    step(1, 0, 0, 4'b0000, 4'b0010, ex(0,0,1,0,0,0), "drain_handover");
    step(1, 0, 0, 4'b0000, 4'b0010, ex(0,1,1,0,0,0), "drain_pass_src1");

    // Drain timeout 1 -> 3, with a rejected request during the guard gap
    step(1, 1, 3, 4'b0000, 4'b1010, ex(0,1,1,1,0,0), "to_accept");
    for (int i = 0; i < 7; i++) step(1, 0, 0, 4'b0000, 4'b1010, ex(0,1,1,1,0,0), "to_drain");
    step(1, 0, 0, 4'b0000, 4'b1010, ex(0,1,1,1,0,1), "to_pulse");
    step(1, 0, 0, 4'b0000, 4'b1010, ex(0,0,1,1,0,0), "to_guard");
    step(1, 1, 0, 4'b0000, 4'b1010, ex(0,0,1,1,1,0), "guard_busy_reject");
    step(1, 0, 0, 4'b0000, 4'b1010, ex(0,0,1,1,0,0), "to_guard");
    step(1, 0, 0, 4'b0000, 4'b1010, ex(0,0,3,0,0,0), "to_handover");
    step(1, 0, 0, 4'b0000, 4'b1010, ex(0,1,3,0,0,0), "to_pass_src3");

    // Reset on guard cycle 2 of a 3 -> 1 switch
    step(1, 1, 1, 4'b1001, 4'b0000, ex(1,0,3,1,0,0), "rg_accept");
    step(1, 0, 0, 4'b1001, 4'b0000, ex(0,0,3,1,0,0), "rg_guard1");
    step(0, 0, 0, 4'b1001, 4'b0000, ex(0,0,0,0,0,0), "rg_reset");
    for (int i = 0; i < 6; i++) step(1, 0, 0, 4'b1001, 4'b0001, ex(1,1,0,0,0,0), "rg_no_switch");

    bus.sel_valid = 1'b0;
    for (int i = 0; i < 10 && sb.size() > 0; i++) begin
      @(negedge clk_sys);
      #1;
    end
    if (sb.size() > 0) begin
      fails++;
      $display("FAIL drain_queue: got %0d unchecked entries, expected 0", sb.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
